// File: rtl/display_pkg.sv
// Shared encodings and defaults for the display scanning blocks.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  // Truncated to the pattern width at the point of use; active-low segments all off.
  localparam logic [63:0] BLANK_DEFAULT = '1;

endpackage

// File: rtl/mux_nxw.sv
// N-way, W-bit combinational selector over a flattened input bus.
// Out-of-range selects return zero.
module mux_nxw #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N*W-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]   y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) y = data[i*W +: W];
    end
  end

endmodule

// File: rtl/scan_mux_n.sv
// Time-multiplexed display scanner: walks the enabled channels, blanks between
// slots, and drives shared segment lines plus active-low one-hot channel enables.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | scan stopped, outputs blank; waits for en and a non-empty mask
// ST_GAP  | blanking before a slot, cnt runs 0..GAP-1
// ST_SHOW | channel sel driven on y/an, cnt runs 0..DIV-1
module scan_mux_n
  import display_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 7,
  parameter int DIV  = 50000,
  parameter int GAP  = 2,
  parameter logic [W-1:0] BLANK_VAL = W'(BLANK_DEFAULT),
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic [N_CH*W-1:0]   data_in,
  output logic [W-1:0]        y,
  output logic [N_CH-1:0]     an,
  output logic [SEL_W-1:0]    sel,
  output logic                frame_done
);

  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [SEL_W-1:0] first_ch;
  logic [SEL_W-1:0] next_ch;
  logic [SEL_W-1:0] mux_sel;
  logic [W-1:0]     mux_y;

  function automatic logic [SEL_W-1:0] lowest_ch(input logic [N_CH-1:0] mask);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Circular search starting after cur; lands back on cur when it is the only one set.
  function automatic logic [SEL_W-1:0] circ_next(input logic [SEL_W-1:0] cur,
                                                 input logic [N_CH-1:0]  mask);
    logic [SEL_W-1:0] r;
    logic             found;
    int               idx;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(cur) + k) % N_CH;
      if (!found && mask[idx]) begin
        r     = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N_CH-1:0] onehot_n(input logic [SEL_W-1:0] s);
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = (s != SEL_W'(i));
    return r;
  endfunction

  assign run      = en && (|ch_mask);
  assign first_ch = lowest_ch(ch_mask);
  assign next_ch  = circ_next(sel, ch_mask);

  // The y register must see the channel being loaded on the same edge that sel moves.
  always_comb begin
    mux_sel = sel;
    case (state)
      ST_IDLE: mux_sel = first_ch;
      ST_SHOW: mux_sel = next_ch;
      default: mux_sel = sel;
    endcase
  end

  mux_nxw #(.N(N_CH), .W(W)) u_mux (
    .data (data_in),
    .sel  (mux_sel),
    .y    (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sel        <= '0;
      y          <= BLANK_VAL;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!run) begin
        state <= ST_IDLE;
        cnt   <= '0;
        y     <= BLANK_VAL;
        an    <= '1;
      end else begin
        case (state)
          ST_IDLE: begin
            sel <= first_ch;
            cnt <= '0;
            if (GAP > 0) begin
              state <= ST_GAP;
            end else begin
              state <= ST_SHOW;
              y     <= mux_y;
              an    <= onehot_n(first_ch);
            end
          end
          ST_GAP: begin
            if (cnt == GAP_LAST) begin
              cnt   <= '0;
              y     <= mux_y;
              an    <= onehot_n(sel);
              state <= ST_SHOW;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_SHOW: begin
            if (cnt == DIV_LAST) begin
              cnt        <= '0;
              sel        <= next_ch;
              frame_done <= (next_ch <= sel);
              if (GAP > 0) begin
                state <= ST_GAP;
                y     <= BLANK_VAL;
                an    <= '1;
              end else begin
                y  <= mux_y;
                an <= onehot_n(next_ch);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            y     <= BLANK_VAL;
            an    <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_mux_n.sv
// Directed bench for scan_mux_n: hand-derived per-cycle expectations are queued
// as stimulus is applied and compared one cycle at a time.
module tb_scan_mux_n;

  logic        clk;
  logic        rst_n;
  logic        en, en0;
  logic [3:0]  ch_mask, ch_mask0;
  logic [27:0] data_in, data_in0;
  logic [6:0]  y, y0;
  logic [3:0]  an, an0;
  logic [1:0]  sel, sel0;
  logic        frame_done, frame_done0;

  int checks;
  int failures;

  typedef struct {
    logic [6:0] y;
    logic [3:0] an;
    logic [1:0] sel;
    logic       fd;
  } exp_t;

  exp_t q[$];

  scan_mux_n #(.N_CH(4), .W(7), .DIV(4), .GAP(1), .BLANK_VAL(7'h7F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ch_mask    (ch_mask),
    .data_in    (data_in),
    .y          (y),
    .an         (an),
    .sel        (sel),
    .frame_done (frame_done)
  );

  scan_mux_n #(.N_CH(4), .W(7), .DIV(1), .GAP(0), .BLANK_VAL(7'h7F)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en0),
    .ch_mask    (ch_mask0),
    .data_in    (data_in0),
    .y          (y0),
    .an         (an0),
    .sel        (sel0),
    .frame_done (frame_done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] an_of(input int ch);
    logic [3:0] r;
    r = 4'hF;
    r[ch] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] vy, input logic [3:0] van, input int ch, input logic fd);
    exp_t e;
    e.y   = vy;
    e.an  = van;
    e.sel = 2'(ch);
    e.fd  = fd;
    q.push_back(e);
  endtask

  task automatic push_gap(input int ch, input logic fd);
    push(7'h7F, 4'hF, ch, fd);
  endtask

  task automatic push_show(input int ch, input logic [6:0] v, input int n);
    for (int i = 0; i < n; i++) push(v, an_of(ch), ch, 1'b0);
  endtask

  task automatic push_chan(input int ch, input logic [6:0] v, input logic fd);
    push_gap(ch, fd);
    push_show(ch, v, 4);
  endtask

  // Advances n clocks, comparing the selected DUT against the queue head each cycle.
  task automatic run_check(input int n, input bit which);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        chk("queue_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        if (which) begin
          chk("y0", 32'(y0), 32'(e.y));
          chk("an0", 32'(an0), 32'(e.an));
          chk("sel0", 32'(sel0), 32'(e.sel));
          chk("frame_done0", 32'(frame_done0), 32'(e.fd));
        end else begin
          chk("y", 32'(y), 32'(e.y));
          chk("an", 32'(an), 32'(e.an));
          chk("sel", 32'(sel), 32'(e.sel));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    en0      = 1'b0;
    ch_mask  = 4'h0;
    ch_mask0 = 4'h0;
    data_in  = {7'h04, 7'h03, 7'h02, 7'h01};
    data_in0 = {7'h04, 7'h03, 7'h02, 7'h01};

    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rst_y", 32'(y), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);

    // Full scan of all four channels, including the frame wrap.
    @(posedge clk);
    #1;
    en      = 1'b1;
    ch_mask = 4'hF;
    push_chan(0, 7'h01, 1'b0);
    push_chan(1, 7'h02, 1'b0);
    push_chan(2, 7'h03, 1'b0);
    push_chan(3, 7'h04, 1'b0);
    push_chan(0, 7'h01, 1'b1);
    run_check(25, 1'b0);

    // Skip masked channels; mask taken at the coming slot advance.
    ch_mask = 4'b1010;
    push_chan(1, 7'h02, 1'b0);
    push_chan(3, 7'h04, 1'b0);
    push_chan(1, 7'h02, 1'b1);
    push_chan(3, 7'h04, 1'b0);
    push_chan(1, 7'h02, 1'b1);
    run_check(25, 1'b0);

    // Single enabled channel wraps onto itself every slot.
    ch_mask = 4'b0100;
    push_chan(2, 7'h03, 1'b0);
    push_chan(2, 7'h03, 1'b1);
    push_chan(2, 7'h03, 1'b1);
    run_check(15, 1'b0);

    ch_mask = 4'hF;
    push_chan(3, 7'h04, 1'b0);
    push_gap(0, 1'b1);
    push_show(0, 7'h01, 2);
    run_check(8, 1'b0);

    // Data and mask change inside channel 0's slot: slot completes unchanged.
    data_in[6:0] = 7'h55;
    ch_mask      = 4'b1110;
    push_show(0, 7'h01, 2);
    push_chan(1, 7'h02, 1'b0);
    push_chan(2, 7'h03, 1'b0);
    push_chan(3, 7'h04, 1'b0);
    push_gap(1, 1'b1);
    push_show(1, 7'h02, 2);
    run_check(20, 1'b0);

    // Disable mid-slot: blank, sel held, no frame pulse.
    en = 1'b0;
    push(7'h7F, 4'hF, 1, 1'b0);
    push(7'h7F, 4'hF, 1, 1'b0);
    push(7'h7F, 4'hF, 1, 1'b0);
    run_check(3, 1'b0);

    en = 1'b1;
    push_chan(1, 7'h02, 1'b0);
    push_chan(2, 7'h03, 1'b0);
    run_check(10, 1'b0);

    // Asynchronous reset between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'h7F);
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_sel", 32'(sel), 32'h0);
    chk("arst_fd", 32'(frame_done), 32'h0);
    en = 1'b0;
    #1;
    rst_n = 1'b1;

    // GAP=0, DIV=1 build: rotate every cycle with no blanking.
    en0      = 1'b1;
    ch_mask0 = 4'hF;
    push(7'h01, 4'b1110, 0, 1'b0);
    push(7'h02, 4'b1101, 1, 1'b0);
    push(7'h03, 4'b1011, 2, 1'b0);
    push(7'h04, 4'b0111, 3, 1'b0);
    push(7'h01, 4'b1110, 0, 1'b1);
    push(7'h02, 4'b1101, 1, 1'b0);
    run_check(6, 1'b1);

    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_mux_n.md
Name: scan_mux_n

Overview:
- Parametrised, time-multiplexed display scanner for N channels of W-bit segment/LED patterns.
- Cycles through enabled channels only, holding each for a programmable slot length with an optional blanking gap to suppress ghosting.
- Drives shared segment lines plus one-hot active-low channel enables.
- Sits between game logic (per-digit patterns) and board display pins.

Parameters:
- N_CH, 8, number of channels (>=2); SEL_W = $clog2(N_CH) is a derived localparam.
- W, 7, pattern width per channel.
- DIV, 50000, clock cycles per channel show slot (>=1).
- GAP, 2, blanking cycles before each slot (0 = no gap).
- BLANK_VAL, {W{1'b1}}, value driven on y while blanked (active-low segments off).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- ch_mask  in  N_CH  1 = channel participates in scan
- data_in  in  N_CH*W  flattened patterns; channel i = data_in[i*W +: W]
- y  out  W  registered pattern of current channel
- an  out  N_CH  one-hot active-low channel enable; all ones when blanked
- sel  out  SEL_W  index of current or last channel shown
- frame_done  out  1  one-cycle pulse when scan wraps past the last enabled channel

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, sel=0, y=BLANK_VAL, an=all ones, frame_done=0.
- Outputs are all registered; no combinational path from inputs to outputs.
- States: IDLE, GAP, SHOW.
- IDLE:
  - y=BLANK_VAL, an=all ones.
  - When en=1 and ch_mask!=0, sel loads the lowest set mask bit and cnt=0.
  - Next state is GAP if GAP>0, else SHOW.
- GAP:
  - y=BLANK_VAL, an=all ones, cnt counts 0..GAP-1.
  - At cnt==GAP-1: y latches data_in[sel], an[sel]=0, cnt=0, next state SHOW.
- SHOW:
  - y and an held for exactly DIV cycles.
  - data_in changes mid-slot are not reflected until the next slot.
- End of SHOW (cnt==DIV-1):
  - sel advances to the next set ch_mask bit, searching circularly from sel+1.
  - If the new sel <= old sel (wrap, including single enabled channel), frame_done=1 for one cycle.
  - If GAP>0: next state GAP, with blanking applied.
  - If GAP==0: stay in SHOW, y and an switch directly to the new channel.
- Latency: en sampled 1 in IDLE at cycle t gives first active an at cycle t+1+GAP.
- Mask rules:
  - Mask is sampled only at slot advance and IDLE exit.
  - A channel cleared during its own slot completes that slot.
- en=0 or ch_mask==0 in any state:
  - Next cycle enters IDLE with blank outputs; no frame_done.
  - sel holds its value; resume restarts from the lowest enabled channel.
- Reset mid-slot: immediate return to reset values, independent of clk.
- cnt width is $clog2(max(DIV,GAP)+1); no overflow for any legal parameters.

Decomposition:
- Shared package display_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_GAP=2'd1, ST_SHOW=2'd2.
  - default BLANK_VAL constant.
- Natural sub-module: mux_nxw (parametrised N-way W-bit combinational mux, generalising the existing fixed 8-way muxes), used to select data_in[sel] into the y register.
- Circular next-channel search stays in a function inside scan_mux_n.

Test Plan (N_CH=4, W=7, DIV=4, GAP=1, BLANK_VAL=7'h7F unless noted):
- Reset and start:
  - Stimulus: rst_n=0, then release; en=1, ch_mask=4'hF, data = {7'h04,7'h03,7'h02,7'h01}.
  - Required: y/an blank for 1 gap cycle; then y=7'h01, an=4'b1110 for 4 cycles.
  - Then gap, 7'h02/4'b1101, and so on; frame_done pulses once after channel 3's slot ends.
- Masked skip:
  - Stimulus: ch_mask=4'b1010.
  - Required: sequence is sel 1, 3, 1, 3...; channels 0 and 2 never enabled on an; frame_done after each sel=3 slot.
- Single channel:
  - Stimulus: ch_mask=4'b0100.
  - Required: an toggles between 4'b1011 (4 cycles) and 4'b1111 (1 cycle); frame_done every 5 cycles.
- Mid-slot data and mask change:
  - Stimulus: change data_in[0] to 7'h55 and clear mask bit 0 in cycle 2 of channel 0's slot.
  - Required: y stays 7'h01 to slot end, then moves to channel 1.
- Disable and async reset:
  - Stimulus: en=0 mid-SHOW.
  - Required: next cycle y=7'h7F, an=4'hF, no frame_done.
  - Stimulus: re-enable.
  - Required: restart at the lowest enabled channel.
  - Stimulus: assert rst_n=0 between clock edges.
  - Required: outputs reset immediately.
- GAP=0, DIV=1 build:
  - Stimulus: ch_mask=4'hF.
  - Required: an rotates 1110, 1101, 1011, 0111 on consecutive cycles with no blanking; frame_done in the cycle after 0111.
